nec_ir_transmitter: RTL and testbench

NEC_IR_TRANSMITTER -- requirements
Module: nec_ir_transmitter

---
 rtl/nec_ir_pkg.sv | 53 +++++
 rtl/nec_ir_tick_gen.sv | 43 ++++
 rtl/nec_ir_transmitter.sv | 184 ++++++++++++++++++
 tb/tb_nec_ir_transmitter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nec_ir_pkg.sv
// ============================================================================
// Module   : nec_ir_pkg
// Brief    : Shared NEC IR protocol constants, FSM encoding and segment helpers
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nec_ir_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LEAD_MARK  = 3'd1,
        LEAD_SPACE = 3'd2,
        REP_SPACE  = 3'd3,
        BIT_MARK   = 3'd4,
        BIT_SPACE  = 3'd5,
        STOP_MARK  = 3'd6,
        GAP        = 3'd7
    } nec_state_e;

    localparam logic [4:0] LEAD_MARK_TICKS  = 5'd16;
    localparam logic [4:0] LEAD_SPACE_TICKS = 5'd8;
    localparam logic [4:0] BIT_MARK_TICKS   = 5'd1;
    localparam logic [4:0] ZERO_SPACE_TICKS = 5'd1;
    localparam logic [4:0] ONE_SPACE_TICKS  = 5'd3;
    localparam logic [4:0] STOP_MARK_TICKS  = 5'd1;
    localparam logic [4:0] REP_SPACE_TICKS  = 5'd4;
    localparam logic [4:0] GAP_TICKS        = 5'd16;

    function automatic logic is_mark(input nec_state_e s);
        return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
    endfunction

    // Length of the segment a state represents; bit_val selects the data space.
    function automatic logic [4:0] seg_ticks(input nec_state_e s, input logic bit_val);
        logic [4:0] t;
        t = 5'd1;
        case (s)
            LEAD_MARK:  t = LEAD_MARK_TICKS;
            LEAD_SPACE: t = LEAD_SPACE_TICKS;
            REP_SPACE:  t = REP_SPACE_TICKS;
            BIT_MARK:   t = BIT_MARK_TICKS;
            BIT_SPACE:  t = bit_val ? ONE_SPACE_TICKS : ZERO_SPACE_TICKS;
            STOP_MARK:  t = STOP_MARK_TICKS;
            GAP:        t = GAP_TICKS;
            default:    t = 5'd1;
        endcase
        return t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nec_ir_tick_gen.sv
// ============================================================================
// Module   : nec_ir_tick_gen
// Brief    : Protocol tick prescaler; one-cycle tick every max(period,1) cycles
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nec_ir_tick_gen #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] period,
    output logic             tick
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] last_cnt;

    always_comb begin
        last_cnt = (period == '0) ? '0 : (period - ONE);
        tick     = !clear && (cnt_q == last_cnt);
        cnt_d    = cnt_q + ONE;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/nec_ir_transmitter.sv
// ============================================================================
// Module   : nec_ir_transmitter
// Brief    : NEC IR frame/repeat-code transmitter with optional carrier
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nec_ir_transmitter
    import nec_ir_pkg::*;
#(
    parameter int PSC_WIDTH = 16,
    parameter int CAR_WIDTH = 12
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [PSC_WIDTH-1:0] tick_period,
    input  logic                 carrier_en,
    input  logic [CAR_WIDTH-1:0] carrier_half,
    input  logic                 cmd_valid,
    input  logic                 cmd_repeat,
    input  logic [7:0]           cmd_addr,
    input  logic [7:0]           cmd_data,
    output logic                 cmd_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 ir_out
);

    localparam logic [CAR_WIDTH-1:0] CAR_ONE = {{(CAR_WIDTH-1){1'b0}}, 1'b1};

    nec_state_e           state_q, state_d;
    logic [7:0]           addr_q, addr_d;
    logic [7:0]           data_q, data_d;
    logic                 rep_q, rep_d;
    logic [PSC_WIDTH-1:0] period_q, period_d;
    logic                 car_en_q, car_en_d;
    logic [CAR_WIDTH-1:0] car_half_q, car_half_d;
    logic [4:0]           tick_cnt_q, tick_cnt_d;
    logic [4:0]           bit_idx_q, bit_idx_d;
    logic [CAR_WIDTH-1:0] car_cnt_q, car_cnt_d;
    logic                 phase_q, phase_d;
    logic                 ir_out_q, ir_out_d;
    logic                 done_q, done_d;
    logic                 ready_q, ready_d;

    logic                 tick;
    logic                 accept;
    logic [31:0]          frame_word;
    logic                 cur_bit;
    logic [4:0]           seg_len;
    logic                 seg_end;
    logic                 mark_next;
    logic [CAR_WIDTH-1:0] car_last;

    // Holding the prescaler clear in IDLE aligns every segment to acceptance.
    nec_ir_tick_gen #(
        .WIDTH (PSC_WIDTH)
    ) u_tick_gen (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clear  (state_q == IDLE),
        .period (period_q),
        .tick   (tick)
    );

    assign accept     = cmd_valid && ready_q;
    assign frame_word = {~data_q, data_q, ~addr_q, addr_q};
    assign cur_bit    = frame_word[bit_idx_q];
    assign seg_len    = seg_ticks(state_q, cur_bit);
    assign seg_end    = tick && (tick_cnt_q == (seg_len - 5'd1));
    assign car_last   = (car_half_q == '0) ? '0 : (car_half_q - CAR_ONE);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rep_d      = rep_q;
        period_d   = period_q;
        car_en_d   = car_en_q;
        car_half_d = car_half_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        car_cnt_d  = car_cnt_q;
        phase_d    = phase_q;
        done_d     = 1'b0;

        if (state_q == IDLE) begin
            if (accept) begin
                state_d    = LEAD_MARK;
                addr_d     = cmd_addr;
                data_d     = cmd_data;
                rep_d      = cmd_repeat;
                period_d   = tick_period;
                car_en_d   = carrier_en;
                car_half_d = carrier_half;
                tick_cnt_d = 5'd0;
                bit_idx_d  = 5'd0;
            end
        end else if (seg_end) begin
            tick_cnt_d = 5'd0;
            case (state_q)
                LEAD_MARK:  state_d = rep_q ? REP_SPACE : LEAD_SPACE;
                LEAD_SPACE: state_d = BIT_MARK;
                BIT_MARK:   state_d = BIT_SPACE;
                BIT_SPACE: begin
                    if (bit_idx_q != 5'd31) begin
                        state_d   = BIT_MARK;
                        bit_idx_d = bit_idx_q + 5'd1;
                    end else begin
                        state_d   = STOP_MARK;
                    end
                end
                REP_SPACE:  state_d = STOP_MARK;
                STOP_MARK:  state_d = GAP;
                GAP: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                default:    state_d = IDLE;
            endcase
        end else if (tick) begin
            tick_cnt_d = tick_cnt_q + 5'd1;
        end

        // Carrier phase restarts high on every mark entry.
        mark_next = is_mark(state_d);
        if (mark_next && !is_mark(state_q)) begin
            car_cnt_d = '0;
            phase_d   = 1'b1;
        end else if (mark_next) begin
            if (car_cnt_q == car_last) begin
                car_cnt_d = '0;
                phase_d   = ~phase_q;
            end else begin
                car_cnt_d = car_cnt_q + CAR_ONE;
            end
        end

        ir_out_d = mark_next && (!car_en_d || phase_d);
        ready_d  = (state_d == IDLE);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            rep_q      <= 1'b0;
            period_q   <= '0;
            car_en_q   <= 1'b0;
            car_half_q <= '0;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            car_cnt_q  <= '0;
            phase_q    <= 1'b0;
            ir_out_q   <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rep_q      <= rep_d;
            period_q   <= period_d;
            car_en_q   <= car_en_d;
            car_half_q <= car_half_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            car_cnt_q  <= car_cnt_d;
            phase_q    <= phase_d;
            ir_out_q   <= ir_out_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign ir_out    = ir_out_q;

endmodule

`default_nettype wire

// File: tb/tb_nec_ir_transmitter.sv
// ============================================================================
// Module   : tb_nec_ir_transmitter
// Brief    : Scoreboard bench; monitor captures each frame and checks on done
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_nec_ir_transmitter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] tick_period = '0;
    logic        carrier_en = 1'b0;
    logic [11:0] carrier_half = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_repeat = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [7:0]  cmd_data = '0;
    logic        cmd_ready, busy, done, ir_out;

    always #5 clk = ~clk;

    nec_ir_transmitter #(
        .PSC_WIDTH (16),
        .CAR_WIDTH (12)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .tick_period  (tick_period),
        .carrier_en   (carrier_en),
        .carrier_half (carrier_half),
        .cmd_valid    (cmd_valid),
        .cmd_repeat   (cmd_repeat),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .cmd_ready    (cmd_ready),
        .busy         (busy),
        .done         (done),
        .ir_out       (ir_out)
    );

    typedef struct {
        bit        rep;
        bit [7:0]  addr;
        bit [7:0]  data;
        bit [15:0] period;
        bit        ce;
        bit [11:0] half;
    } exp_t;

    exp_t exp_q[$];
    bit   exp_bits[$];
    bit   cur[$];
    bit   last_bits[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   idle_viol = 0;
    int   ready_viol = 0;
    int   n_done = 0;

    // Reference waveform: one entry per busy cycle, built from protocol timing.
    function automatic void add_seg(input bit mark, input int ticks, input int p,
                                    input bit ce, input int h);
        for (int c = 0; c < ticks * p; c++) begin
            exp_bits.push_back(mark && (!ce || ((c / h) % 2 == 0)));
        end
    endfunction

    function automatic void build_wave(input exp_t e);
        int p;
        int h;
        bit [31:0] w;
        p = (e.period == 0) ? 1 : int'(e.period);
        h = (e.half == 0) ? 1 : int'(e.half);
        w = {~e.data, e.data, ~e.addr, e.addr};
        exp_bits.delete();
        add_seg(1'b1, 16, p, e.ce, h);
        if (e.rep) begin
            add_seg(1'b0, 4, p, e.ce, h);
        end else begin
            add_seg(1'b0, 8, p, e.ce, h);
            for (int k = 0; k < 32; k++) begin
                add_seg(1'b1, 1, p, e.ce, h);
                add_seg(1'b0, w[k] ? 3 : 1, p, e.ce, h);
            end
        end
        add_seg(1'b1, 1, p, e.ce, h);
        add_seg(1'b0, 16, p, e.ce, h);
    endfunction

    function automatic int run_len(input int s);
        int n;
        n = 0;
        while ((s + n) < last_bits.size() && last_bits[s + n] == last_bits[s]) n++;
        return n;
    endfunction

    // Independent pulse-distance decoder over the last captured frame.
    function automatic bit [31:0] decode(input int p);
        int idx;
        int sl;
        bit [31:0] w;
        w   = '0;
        idx = run_len(0);
        idx = idx + run_len(idx);
        for (int k = 0; k < 32; k++) begin
            idx = idx + run_len(idx);
            sl  = run_len(idx);
            w[k] = (sl > 2 * p);
            idx = idx + sl;
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: record ir_out while busy; on done, pop expectation and compare.
    initial begin : monitor
        exp_t e;
        int   mism;
        bit   done_prev;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                cur.delete();
                done_prev = 1'b0;
            end else begin
                if (busy === 1'b1) cur.push_back(ir_out);
                if (busy !== 1'b1 && ir_out === 1'b1) idle_viol++;
                if (busy === 1'b1 && cmd_ready === 1'b1) ready_viol++;
                if (done_prev) begin
                    checks++;
                    if (done !== 1'b0) begin
                        errors++;
                        $display("FAIL done_width actual=%b required=0", done);
                    end
                end
                if (done === 1'b1) begin
                    checks++;
                    if (cmd_ready !== 1'b1) begin
                        errors++;
                        $display("FAIL done_ready actual=%b required=1", cmd_ready);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done actual=1 required=0");
                    end else begin
                        e = exp_q.pop_front();
                        build_wave(e);
                        mism = -1;
                        for (int i = 0; i < cur.size() && i < exp_bits.size(); i++) begin
                            if (mism < 0 && cur[i] != exp_bits[i]) mism = i;
                        end
                        if (mism >= 0 || cur.size() != exp_bits.size()) begin
                            errors++;
                            $display("FAIL frame_wave addr=%0h len actual=%0d required=%0d first_diff=%0d",
                                     e.addr, cur.size(), exp_bits.size(), mism);
                        end
                    end
                    last_bits = cur;
                    cur.delete();
                    done_cnt++;
                end
                done_prev = (done === 1'b1);
            end
        end
    end

    task automatic send(input bit rep, input bit [7:0] a, input bit [7:0] d,
                        input bit [15:0] p, input bit ce, input bit [11:0] h,
                        input bit expect_done);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready_wait", cmd_ready, 1);
        cmd_valid    = 1'b1;
        cmd_repeat   = rep;
        cmd_addr     = a;
        cmd_data     = d;
        tick_period  = p;
        carrier_en   = ce;
        carrier_half = h;
        if (expect_done) begin
            e.rep = rep; e.addr = a; e.data = d; e.period = p; e.ce = ce; e.half = h;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("accept_ir_out", ir_out, 1);
        chk("accept_busy", busy, 1);
        @(negedge clk);
        cmd_valid    = 1'b0;
        cmd_repeat   = ~rep;
        cmd_addr     = ~a;
        cmd_data     = ~d;
        tick_period  = p + 16'd3;
        carrier_en   = ~ce;
        carrier_half = h + 12'd1;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_arrived", (done_cnt >= target) ? 1 : 0, 1);
    endtask

    initial begin : stim
        int        last1;
        bit [19:0] pat;
        bit [19:0] act;
        bit [31:0] w;
        bit [7:0]  ra;
        bit [7:0]  rd;
        bit        p0_bits[$];
        int        diffs;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ir_out", ir_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", cmd_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", cmd_ready, 1);

        // Normal frame, no carrier
        send(1'b0, 8'h5A, 8'hC3, 16'd4, 1'b0, 12'd0, 1'b1);
        n_done++;
        wait_done(n_done, 2000);
        last1 = -1;
        for (int i = 0; i < last_bits.size(); i++) if (last_bits[i]) last1 = i;
        chk("t1_len", last_bits.size(), 548);
        chk("t1_lead_mark", run_len(0), 64);
        chk("t1_lead_space", run_len(64), 32);
        chk("t1_frame_len", last1 + 1, 484);
        chk("t1_gap", last_bits.size() - (last1 + 1), 64);
        chk("t1_decode", decode(4), 32'h3CC3A55A);

        // Repeat code: addr/data irrelevant
        send(1'b1, 8'hFF, 8'h00, 16'd4, 1'b0, 12'd0, 1'b1);
        n_done++;
        wait_done(n_done, 2000);
        chk("t2_len", last_bits.size(), 148);
        chk("t2_lead_mark", run_len(0), 64);
        chk("t2_rep_space", run_len(64), 16);
        chk("t2_stop_mark", run_len(80), 4);
        chk("t2_gap", run_len(84), 64);

        // Carrier modulation
        send(1'b0, 8'h5A, 8'hC3, 16'd20, 1'b1, 12'd2, 1'b1);
        n_done++;
        wait_done(n_done, 5000);
        pat = 20'b11001100110011001100;
        for (int c = 0; c < 20; c++) act[19 - c] = last_bits[480 + c];
        chk("t3_bit0_mark", act, pat);
        for (int c = 0; c < 20; c++) act[19 - c] = last_bits[520 + c];
        chk("t3_bit1_mark", act, pat);

        // Request while busy is dropped, not queued
        send(1'b0, 8'h11, 8'h22, 16'd2, 1'b0, 12'd0, 1'b1);
        n_done++;
        repeat (50) @(negedge clk);
        chk("busy_ready_low", cmd_ready, 0);
        cmd_valid = 1'b1;
        cmd_addr  = 8'h99;
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(n_done, 2000);
        repeat (10) @(negedge clk);
        chk("busy_not_queued", busy, 0);

        // Back-to-back requests
        send(1'b0, 8'h01, 8'h80, 16'd2, 1'b0, 12'd0, 1'b1);
        send(1'b1, 8'h00, 8'h00, 16'd3, 1'b0, 12'd0, 1'b1);
        n_done += 2;
        wait_done(n_done, 3000);

        // tick_period 0 behaves as 1
        send(1'b0, 8'hA5, 8'h0F, 16'd0, 1'b0, 12'd0, 1'b1);
        n_done++;
        wait_done(n_done, 1000);
        chk("p0_len", last_bits.size(), 137);
        p0_bits = last_bits;
        send(1'b0, 8'hA5, 8'h0F, 16'd1, 1'b0, 12'd0, 1'b1);
        n_done++;
        wait_done(n_done, 1000);
        diffs = (p0_bits.size() == last_bits.size()) ? 0 : 1;
        for (int i = 0; i < p0_bits.size() && i < last_bits.size(); i++)
            if (p0_bits[i] != last_bits[i]) diffs++;
        chk("p0_equals_p1", diffs, 0);

        // Reset during bit 10 mark (cycles 216..219 after acceptance)
        send(1'b0, 8'h5A, 8'hC3, 16'd4, 1'b0, 12'd0, 1'b0);
        repeat (217) @(negedge clk);
        chk("bit10_mark_high", ir_out, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ir_out", ir_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cmd_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_ready_release", cmd_ready, 1);
        repeat (20) @(negedge clk);
        chk("midrst_no_done", done_cnt, n_done);

        // Loopback decode of random pairs
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom);
            rd = 8'($urandom);
            send(1'b0, ra, rd, 16'd1, 1'b0, 12'd0, 1'b1);
            n_done++;
            wait_done(n_done, 1000);
            w = decode(1);
            chk("loop_addr", w[7:0], ra);
            chk("loop_data", w[23:16], rd);
        end

        repeat (5) @(negedge clk);
        chk("idle_ir_low", idle_viol, 0);
        chk("ready_only_idle", ready_viol, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
